// File: rtl/oc8051_stack_seq.sv
// oc8051_stack_seq
// ----------------
// Stack-operation sequencer that sits between the decoder/PC logic and the
// internal-RAM / stack-pointer path. One decoded stack op (PUSH, POP, CALL,
// RET, RETI) is expanded into a cycle-by-cycle sequence of RAM select codes,
// write strobes and data. It also captures the popped byte or return PC.
// Only one op is handled at a time. There is no back-to-back acceptance, so
// at least one IDLE cycle separates two ops.
//
// Optional build macro: OC8051_STACK_GUARD_EN
//   When this macro is defined, the block checks for overflow and underflow
//   at op start. A guarded op keeps its normal timing, but its RAM
//   strobes/selects are suppressed and any captured value is forced to 0.
//   The sticky stk_err flag is then set.
//   When the macro is undefined, stk_err is tied to 0.
//
// Ports
//   clk          in   clock, all state on rising edge
//   rst          in   asynchronous reset, active low
//   start        in   op request, accepted only in IDLE
//   op[2:0]      in   001 PUSH, 010 POP, 011 CALL, 100 RET, 101 RETI
//   data_in[7:0] in   byte to PUSH, latched at start
//   pc_in[15:0]  in   return address for CALL, latched at start
//   sp_in[7:0]   in   current SP (used only by the guard)
//   ram_rd_data  in   RAM read data, valid one cycle after a read select
//   ram_rd_sel   out  read select to SP block / RAM
//   ram_wr_sel   out  write select to SP block / RAM
//   ram_wr       out  RAM write strobe
//   ram_wr_data  out  RAM write data
//   pop_data     out  byte captured by POP, held until next POP
//   pc_out       out  return PC from RET/RETI, held until next RET/RETI
//   pc_load      out  one-cycle pulse, pc_out valid
//   irq_clr      out  one-cycle pulse on RETI completion
//   busy         out  sequencer not idle
//   done         out  final cycle of every op
//   err          out  one-cycle pulse: illegal op, or start while busy
//   stk_err      out  sticky guard flag

`ifndef OC8051_RWS_SP
`define OC8051_RWS_SP 3'b011
`endif
`ifndef OC8051_RRS_SP
`define OC8051_RRS_SP 3'b011
`endif

module oc8051_stack_seq #(
  parameter logic [2:0] RWS_SP   = `OC8051_RWS_SP,
  parameter logic [2:0] RRS_SP   = `OC8051_RRS_SP,
  parameter logic [2:0] SEL_IDLE = 3'b000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [7:0]  data_in,
  input  logic [15:0] pc_in,
  input  logic [7:0]  sp_in,
  input  logic [7:0]  ram_rd_data,
  output logic [2:0]  ram_rd_sel,
  output logic [2:0]  ram_wr_sel,
  output logic        ram_wr,
  output logic [7:0]  ram_wr_data,
  output logic [7:0]  pop_data,
  output logic [15:0] pc_out,
  output logic        pc_load,
  output logic        irq_clr,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        stk_err
);

  localparam logic [2:0] OP_PUSH = 3'b001;
  localparam logic [2:0] OP_POP  = 3'b010;
  localparam logic [2:0] OP_CALL = 3'b011;
  localparam logic [2:0] OP_RET  = 3'b100;
  localparam logic [2:0] OP_RETI = 3'b101;

  typedef enum logic [3:0] {
    S_IDLE, S_PUSH_W1, S_CALL_WL, S_CALL_WH,
    S_POP_R1, S_POP_C1, S_RET_R1, S_RET_R2, S_RET_C2
  } state_t;

  state_t      state, state_next;
  logic [7:0]  data_lat;
  logic [15:0] pc_lat;
  logic        reti_lat;
  logic [7:0]  hi_byte;
  logic [7:0]  pop_hold;
  logic [15:0] pc_hold;
  logic        guard_q;
  logic        legal;
  logic        accept;

  assign legal  = (op >= OP_PUSH) && (op <= OP_RETI);
  assign accept = (state == S_IDLE) && start && legal;
  assign busy   = (state != S_IDLE);

  // State register plus operand latches. The popped byte and the return PC
  // are registered at the end of their completion cycle. The outputs then
  // hold those values until the next op of the same kind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      data_lat <= 8'h00;
      pc_lat   <= 16'h0000;
      reti_lat <= 1'b0;
      hi_byte  <= 8'h00;
      pop_hold <= 8'h00;
      pc_hold  <= 16'h0000;
      err      <= 1'b0;
    end else begin
      state <= state_next;
      err   <= start && (busy || !legal);
      if (accept) begin
        data_lat <= data_in;
        pc_lat   <= pc_in;
        reti_lat <= (op == OP_RETI);
      end
      if (state == S_RET_R2) hi_byte <= guard_q ? 8'h00 : ram_rd_data;
      if (state == S_POP_C1) pop_hold <= pop_data;
      if (state == S_RET_C2) pc_hold <= pc_out;
    end
  end

  // Next-state and Moore outputs. Because the strobes decode purely from
  // state, they drop the moment the async reset clears the state register.
  // In the completion cycles, pop_data and pc_out pass the RAM data straight
  // through, so the values are valid together with done/pc_load.
  always_comb begin
    state_next  = state;
    ram_rd_sel  = SEL_IDLE;
    ram_wr_sel  = SEL_IDLE;
    ram_wr      = 1'b0;
    ram_wr_data = 8'h00;
    pc_load     = 1'b0;
    irq_clr     = 1'b0;
    done        = 1'b0;
    pop_data    = pop_hold;
    pc_out      = pc_hold;
    case (state)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_PUSH:         state_next = S_PUSH_W1;
            OP_CALL:         state_next = S_CALL_WL;
            OP_POP:          state_next = S_POP_R1;
            OP_RET, OP_RETI: state_next = S_RET_R1;
            default:         state_next = S_IDLE;
          endcase
        end
      end
      S_PUSH_W1: begin
        ram_wr_data = data_lat;
        ram_wr      = !guard_q;
        ram_wr_sel  = guard_q ? SEL_IDLE : RWS_SP;
        done        = 1'b1;
        state_next  = S_IDLE;
      end
      S_CALL_WL: begin
        ram_wr_data = pc_lat[7:0];
        ram_wr      = !guard_q;
        ram_wr_sel  = guard_q ? SEL_IDLE : RWS_SP;
        state_next  = S_CALL_WH;
      end
      S_CALL_WH: begin
        ram_wr_data = pc_lat[15:8];
        ram_wr      = !guard_q;
        ram_wr_sel  = guard_q ? SEL_IDLE : RWS_SP;
        done        = 1'b1;
        state_next  = S_IDLE;
      end
      S_POP_R1: begin
        ram_rd_sel = guard_q ? SEL_IDLE : RRS_SP;
        state_next = S_POP_C1;
      end
      S_POP_C1: begin
        pop_data   = guard_q ? 8'h00 : ram_rd_data;
        done       = 1'b1;
        state_next = S_IDLE;
      end
      S_RET_R1: begin
        ram_rd_sel = guard_q ? SEL_IDLE : RRS_SP;
        state_next = S_RET_R2;
      end
      S_RET_R2: begin
        ram_rd_sel = guard_q ? SEL_IDLE : RRS_SP;
        state_next = S_RET_C2;
      end
      S_RET_C2: begin
        pc_out     = guard_q ? 16'h0000 : {hi_byte, ram_rd_data};
        pc_load    = 1'b1;
        irq_clr    = reti_lat;
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

`ifdef OC8051_STACK_GUARD_EN
  logic guard_hit;

  // Overflow/underflow limits. A CALL needs two free bytes, and a RET needs
  // two stacked bytes.
  always_comb begin
    guard_hit = 1'b0;
    case (op)
      OP_PUSH:         guard_hit = (sp_in == 8'hFF);
      OP_CALL:         guard_hit = (sp_in >= 8'hFE);
      OP_POP:          guard_hit = (sp_in == 8'h00);
      OP_RET, OP_RETI: guard_hit = (sp_in <= 8'h01);
      default:         guard_hit = 1'b0;
    endcase
  end

  // The guard decision is frozen for the whole op. stk_err is sticky until
  // reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      guard_q <= 1'b0;
      stk_err <= 1'b0;
    end else if (accept) begin
      guard_q <= guard_hit;
      if (guard_hit) stk_err <= 1'b1;
    end
  end
`else
  logic sp_unused;

  assign guard_q   = 1'b0;
  assign stk_err   = 1'b0;
  assign sp_unused = ^sp_in;
`endif

endmodule

// File: tb/tb_oc8051_stack_seq.sv
// tb_oc8051_stack_seq
// -------------------
// Self-checking bench for oc8051_stack_seq. A negedge monitor collects the
// RAM writes and done-cycle results into observed queues. Each test pushes
// its expected writes and results into expectation queues, then pops both
// queues and compares them. A small RAM model returns queued bytes one cycle
// after each read select.

`ifndef OC8051_RWS_SP
`define OC8051_RWS_SP 3'b011
`endif
`ifndef OC8051_RRS_SP
`define OC8051_RRS_SP 3'b011
`endif

module tb_oc8051_stack_seq;

  localparam logic [2:0] RWS      = `OC8051_RWS_SP;
  localparam logic [2:0] RRS      = `OC8051_RRS_SP;
  localparam logic [2:0] SEL_IDLE = 3'b000;

  typedef struct packed {
    logic [7:0]  pop;
    logic [15:0] pc;
    logic        ld;
    logic        irq;
  } done_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [7:0]  data_in = 8'h00;
  logic [15:0] pc_in = 16'h0000;
  logic [7:0]  sp_in = 8'h00;
  logic [7:0]  ram_rd_data = 8'h00;
  logic [2:0]  ram_rd_sel, ram_wr_sel;
  logic        ram_wr;
  logic [7:0]  ram_wr_data, pop_data;
  logic [15:0] pc_out;
  logic        pc_load, irq_clr, busy, done, err, stk_err;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int rd_cycles = 0;
  int err_seen = 0;
  int overlap = 0;

  logic [10:0] exp_wr[$];
  logic [10:0] obs_wr[$];
  int          obs_wr_cyc[$];
  done_t       exp_done[$];
  done_t       obs_done[$];
  int          obs_done_cyc[$];
  logic [7:0]  rd_q[$];

  logic [7:0]  pop_model = 8'h00;
  logic [15:0] pc_model = 16'h0000;

  oc8051_stack_seq dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .data_in(data_in),
    .pc_in(pc_in), .sp_in(sp_in), .ram_rd_data(ram_rd_data),
    .ram_rd_sel(ram_rd_sel), .ram_wr_sel(ram_wr_sel), .ram_wr(ram_wr),
    .ram_wr_data(ram_wr_data), .pop_data(pop_data), .pc_out(pc_out),
    .pc_load(pc_load), .irq_clr(irq_clr), .busy(busy), .done(done),
    .err(err), .stk_err(stk_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // RAM model: read data appears one cycle after the read select.
  always @(posedge clk) begin
    if (ram_rd_sel == RRS && rd_q.size() > 0) ram_rd_data <= rd_q.pop_front();
  end

  // Monitor samples mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      if (ram_wr) begin
        obs_wr.push_back({ram_wr_sel, ram_wr_data});
        obs_wr_cyc.push_back(cyc);
      end
      if (ram_rd_sel == RRS) rd_cycles++;
      if (done) begin
        obs_done.push_back(done_t'{pop_data, pc_out, pc_load, irq_clr});
        obs_done_cyc.push_back(cyc);
      end
      if (err) err_seen++;
      if (ram_wr && ram_rd_sel == RRS) overlap++;
    end
  end

  // Presents one op for exactly one sampling edge. sc is the cycle stamp of
  // the op's first sequencer cycle.
  task automatic issue(input logic [2:0] o, input logic [7:0] d,
                       input logic [15:0] p, input logic [7:0] s,
                       output int sc);
    @(posedge clk);
    #1 start = 1'b1; op = o; data_in = d; pc_in = p; sp_in = s;
    @(posedge clk);
    #1 sc = cyc; start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL wait_idle: busy=%b after %0d cycles, want 0", busy, n);
    end
  endtask

  task automatic clear_obs();
    obs_wr.delete(); obs_wr_cyc.delete(); obs_done.delete(); obs_done_cyc.delete();
    rd_cycles = 0; err_seen = 0; overlap = 0;
  endtask

  task automatic test_reset();
    logic [68:0] got, want;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    got  = {ram_rd_sel, ram_wr_sel, ram_wr, ram_wr_data, pop_data, pc_out,
            pc_load, irq_clr, busy, done, err, stk_err, 22'h0, 8'h0};
    want = {SEL_IDLE, SEL_IDLE, 1'b0, 8'h00, 8'h00, 16'h0000,
            1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 22'h0, 8'h0};
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got %h want %h", got, want);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    compared++;
    if ({busy, ram_wr, ram_rd_sel, err} !== {1'b0, 1'b0, SEL_IDLE, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL reset_release_idle: got %b want %b",
               {busy, ram_wr, ram_rd_sel, err}, {1'b0, 1'b0, SEL_IDLE, 1'b0});
    end
    clear_obs();
  endtask

  task automatic test_push();
    int sc;
    logic [10:0] e, o;
    done_t ed, od;
    exp_wr.push_back({RWS, 8'hA5});
    exp_done.push_back(done_t'{pop_model, pc_model, 1'b0, 1'b0});
    issue(3'b001, 8'hA5, 16'h0000, 8'h07, sc);
    @(negedge clk);
    compared++;
    if ({ram_wr, ram_wr_sel, ram_wr_data, done, busy} !== {1'b1, RWS, 8'hA5, 1'b1, 1'b1}) begin
      mismatched++;
      $display("[TB] FAIL push_w1: got %h want %h",
               {ram_wr, ram_wr_sel, ram_wr_data, done, busy}, {1'b1, RWS, 8'hA5, 1'b1, 1'b1});
    end
    @(negedge clk);
    compared++;
    if ({busy, ram_wr, done} !== 3'b000) begin
      mismatched++;
      $display("[TB] FAIL push_after: busy/wr/done=%b want 000", {busy, ram_wr, done});
    end
    compared++;
    if (obs_wr.size() != 1 || obs_done.size() != 1) begin
      mismatched++;
      $display("[TB] FAIL push_counts: writes=%0d dones=%0d want 1 1", obs_wr.size(), obs_done.size());
    end
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      e = exp_wr.pop_front(); o = obs_wr.pop_front();
      compared++;
      if (o !== e) begin
        mismatched++;
        $display("[TB] FAIL push_write: got %h want %h", o, e);
      end
    end
    while (exp_done.size() > 0 && obs_done.size() > 0) begin
      ed = exp_done.pop_front(); od = obs_done.pop_front();
      compared++;
      if (od !== ed || obs_done_cyc[0] != sc) begin
        mismatched++;
        $display("[TB] FAIL push_done: got %h @%0d want %h @%0d", od, obs_done_cyc[0], ed, sc);
      end
    end
    exp_wr.delete(); exp_done.delete(); clear_obs();
  endtask

  task automatic test_call();
    int sc;
    logic [10:0] e, o;
    done_t ed, od;
    exp_wr.push_back({RWS, 8'h34});
    exp_wr.push_back({RWS, 8'h12});
    exp_done.push_back(done_t'{pop_model, pc_model, 1'b0, 1'b0});
    issue(3'b011, 8'h00, 16'h1234, 8'h08, sc);
    wait_idle();
    compared++;
    if (obs_wr.size() != 2 || obs_done.size() != 1) begin
      mismatched++;
      $display("[TB] FAIL call_counts: writes=%0d dones=%0d want 2 1", obs_wr.size(), obs_done.size());
    end else begin
      compared++;
      if (obs_wr_cyc[0] != sc || obs_wr_cyc[1] != sc + 1 || obs_done_cyc[0] != sc + 1) begin
        mismatched++;
        $display("[TB] FAIL call_timing: wl=%0d wh=%0d done=%0d want %0d %0d %0d",
                 obs_wr_cyc[0], obs_wr_cyc[1], obs_done_cyc[0], sc, sc + 1, sc + 1);
      end
    end
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      e = exp_wr.pop_front(); o = obs_wr.pop_front();
      compared++;
      if (o !== e) begin
        mismatched++;
        $display("[TB] FAIL call_write: got %h want %h", o, e);
      end
    end
    while (exp_done.size() > 0 && obs_done.size() > 0) begin
      ed = exp_done.pop_front(); od = obs_done.pop_front();
      compared++;
      if (od !== ed) begin
        mismatched++;
        $display("[TB] FAIL call_done: got %h want %h", od, ed);
      end
    end
    exp_wr.delete(); exp_done.delete(); clear_obs();
  endtask

  task automatic test_ret(input logic reti);
    int sc;
    done_t ed, od;
    rd_q.delete();
    rd_q.push_back(8'h12);
    rd_q.push_back(8'h56);
    pc_model = 16'h1256;
    exp_done.push_back(done_t'{pop_model, 16'h1256, 1'b1, reti});
    issue(reti ? 3'b101 : 3'b100, 8'h00, 16'h0000, 8'h0A, sc);
    wait_idle();
    compared++;
    if (rd_cycles != 2 || obs_wr.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL ret_reads: rd_cycles=%0d writes=%0d want 2 0", rd_cycles, obs_wr.size());
    end
    compared++;
    if (obs_done.size() != 1 || obs_done_cyc[0] != sc + 2) begin
      mismatched++;
      $display("[TB] FAIL ret_timing: dones=%0d want 1 at cycle %0d", obs_done.size(), sc + 2);
    end
    while (exp_done.size() > 0 && obs_done.size() > 0) begin
      ed = exp_done.pop_front(); od = obs_done.pop_front();
      compared++;
      if (od !== ed) begin
        mismatched++;
        $display("[TB] FAIL ret_done(reti=%0b): got %h want %h", reti, od, ed);
      end
    end
    compared++;
    if ({pc_out, pc_load, irq_clr} !== {pc_model, 1'b0, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL ret_hold: pc_out=%h ld=%b irq=%b want %h 0 0", pc_out, pc_load, irq_clr, pc_model);
    end
    exp_done.delete(); clear_obs();
  endtask

  task automatic test_back_to_back();
    int sc;
    done_t ed, od;
    rd_q.delete();
    rd_q.push_back(8'h3C);
    pop_model = 8'h3C;
    exp_done.push_back(done_t'{8'h3C, pc_model, 1'b0, 1'b0});
    issue(3'b010, 8'h00, 16'h0000, 8'h0A, sc);
    @(posedge clk);
    #1 start = 1'b1; op = 3'b001; data_in = 8'hEE;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    compared++;
    if ({err, busy, ram_wr} !== 3'b100) begin
      mismatched++;
      $display("[TB] FAIL start_in_done: err/busy/wr=%b want 100", {err, busy, ram_wr});
    end
    @(posedge clk);
    #1 start = 1'b1; op = 3'b111;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    compared++;
    if ({err, busy, ram_wr, ram_rd_sel} !== {1'b1, 1'b0, 1'b0, SEL_IDLE}) begin
      mismatched++;
      $display("[TB] FAIL illegal_op: err/busy/wr/rd=%b want %b",
               {err, busy, ram_wr, ram_rd_sel}, {1'b1, 1'b0, 1'b0, SEL_IDLE});
    end
    @(negedge clk);
    compared++;
    if (err_seen != 2 || err !== 1'b0 || obs_wr.size() != 0 || overlap != 0) begin
      mismatched++;
      $display("[TB] FAIL err_pulses: pulses=%0d err=%b writes=%0d overlap=%0d want 2 0 0 0",
               err_seen, err, obs_wr.size(), overlap);
    end
    compared++;
    if (obs_done.size() != 1 || obs_done_cyc[0] != sc + 1) begin
      mismatched++;
      $display("[TB] FAIL pop_timing: dones=%0d want 1 at cycle %0d", obs_done.size(), sc + 1);
    end
    while (exp_done.size() > 0 && obs_done.size() > 0) begin
      ed = exp_done.pop_front(); od = obs_done.pop_front();
      compared++;
      if (od !== ed) begin
        mismatched++;
        $display("[TB] FAIL pop_done: got %h want %h", od, ed);
      end
    end
    compared++;
    if (pop_data !== pop_model) begin
      mismatched++;
      $display("[TB] FAIL pop_hold: got %h want %h", pop_data, pop_model);
    end
    exp_done.delete(); clear_obs();
  endtask

  task automatic test_reset_mid_op();
    int sc;
    issue(3'b011, 8'h00, 16'hABCD, 8'h08, sc);
    compared++;
    if ({ram_wr, ram_wr_data} !== {1'b1, 8'hCD}) begin
      mismatched++;
      $display("[TB] FAIL mid_wl: wr/data=%h want %h", {ram_wr, ram_wr_data}, {1'b1, 8'hCD});
    end
    rst = 1'b0;
    pop_model = 8'h00;
    pc_model = 16'h0000;
    #1;
    compared++;
    if ({ram_wr, busy, ram_wr_sel, pop_data, pc_out} !== {1'b0, 1'b0, SEL_IDLE, pop_model, pc_model}) begin
      mismatched++;
      $display("[TB] FAIL mid_reset_async: got %h want %h",
               {ram_wr, busy, ram_wr_sel, pop_data, pc_out}, {1'b0, 1'b0, SEL_IDLE, pop_model, pc_model});
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    clear_obs();
    repeat (3) @(negedge clk);
    compared++;
    if (obs_wr.size() != 0 || obs_done.size() != 0 || busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL mid_no_resume: writes=%0d dones=%0d busy=%b want 0 0 0",
               obs_wr.size(), obs_done.size(), busy);
    end
    clear_obs();
  endtask

  task automatic test_guard();
    int sc;
`ifdef OC8051_STACK_GUARD_EN
    issue(3'b001, 8'h77, 16'h0000, 8'hFF, sc);
    wait_idle();
    compared++;
    if (obs_wr.size() != 0 || obs_done.size() != 1 || stk_err !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL guard_overflow: writes=%0d dones=%0d stk_err=%b want 0 1 1",
               obs_wr.size(), obs_done.size(), stk_err);
    end
    clear_obs();
    exp_wr.push_back({RWS, 8'h88});
    issue(3'b001, 8'h88, 16'h0000, 8'h10, sc);
    wait_idle();
    compared++;
    if (obs_wr.size() != 1 || obs_wr[0] !== exp_wr[0] || stk_err !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL guard_sticky: writes=%0d stk_err=%b want 1 1", obs_wr.size(), stk_err);
    end
`else
    exp_wr.push_back({RWS, 8'h77});
    issue(3'b001, 8'h77, 16'h0000, 8'hFF, sc);
    wait_idle();
    compared++;
    if (obs_wr.size() != 1 || obs_wr[0] !== exp_wr[0] || stk_err !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL noguard_push_ff: writes=%0d stk_err=%b want 1 0", obs_wr.size(), stk_err);
    end
`endif
    exp_wr.delete(); clear_obs();
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    compared++;
    if (stk_err !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL guard_reset_clear: stk_err=%b want 0", stk_err);
    end
  endtask

  initial begin
    test_reset();
    test_push();
    test_call();
    test_ret(1'b0);
    test_ret(1'b1);
    test_back_to_back();
    test_reset_mid_op();
    test_guard();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/oc8051_stack_seq.md
Name: oc8051_stack_seq

Overview:
- Stack-operation sequencer directly upstream of the stack-pointer block.
- Turns one decoded stack op (PUSH, POP, CALL, RET, RETI) into a cycle-by-cycle sequence:
  - RAM read/write select codes for the SP block,
  - RAM write strobes and data,
  - captured pop data or return PC.
- Sits between the decoder/PC logic and the internal-RAM/SP path. Handles one op at a time.

Parameters:
RWS_SP, `OC8051_RWS_SP, ram_wr_sel code meaning "write at SP+1, increment SP"
RRS_SP, `OC8051_RRS_SP, ram_rd_sel code meaning "read at SP, decrement SP next cycle"
SEL_IDLE, 3'b000, select code driven when no stack access (ram_wr=0 in those cycles)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
start  in  1  op request, sampled only in IDLE
op  in  3  001 PUSH, 010 POP, 011 CALL, 100 RET, 101 RETI; others illegal
data_in  in  8  byte to PUSH, latched at start
pc_in  in  16  return address for CALL, latched at start
sp_in  in  8  current SP value from SP block
ram_rd_data  in  8  internal RAM read data, valid one cycle after read select
ram_rd_sel  out  3  read select to SP block/RAM
ram_wr_sel  out  3  write select to SP block/RAM
ram_wr  out  1  RAM write strobe
ram_wr_data  out  8  RAM write data
pop_data  out  8  byte captured by POP, held until next POP
pc_out  out  16  return PC from RET/RETI, held until next RET/RETI
pc_load  out  1  one-cycle pulse, pc_out valid
irq_clr  out  1  one-cycle pulse on RETI completion
busy  out  1  state != IDLE
done  out  1  high in final cycle of every op
err  out  1  one-cycle pulse: illegal op, or start while busy
stk_err  out  1  sticky guard flag (see Optional Feature)

Behaviour:
- Reset values:
  - State IDLE.
  - All outputs 0, except ram_rd_sel and ram_wr_sel, which are SEL_IDLE.
  - pop_data and pc_out are 0.
  - Latched data and PC are 0.
- IDLE:
  - start=1 with a legal op latches data_in and pc_in, then moves to the op's first state next edge.
  - start=1 with an illegal op pulses err the next cycle and stays IDLE.
  - start=0: outputs idle.
- PUSH:
  - W1: ram_wr=1, ram_wr_sel=RWS_SP, ram_wr_data=latched byte, done=1 -> IDLE.
  - Latency: start edge + 1 cycle.
- CALL:
  - WL: ram_wr=1, ram_wr_sel=RWS_SP, data=pc[7:0].
  - WH: same with pc[15:8], done=1 -> IDLE.
  - Low byte is pushed first.
- POP:
  - R1: ram_rd_sel=RRS_SP.
  - C1: pop_data<=ram_rd_data, done=1 -> IDLE.
- RET:
  - R1: ram_rd_sel=RRS_SP.
  - R2: ram_rd_sel=RRS_SP and hi<=ram_rd_data.
  - C2: pc_out<={hi, ram_rd_data}, pc_load=1, done=1 -> IDLE.
  - High byte is popped first.
- RETI: identical to RET, plus irq_clr=1 in C2.
- ram_wr and ram_rd_sel=RRS_SP are never active in the same cycle.
- Outside active write/read states, ram_wr=0 and both selects are SEL_IDLE.
- start while busy:
  - Ignored; err pulses next cycle; sequence unaffected.
  - This includes the done cycle: there is no back-to-back acceptance, so the minimum gap is one IDLE cycle.
- Reset asserted mid-op:
  - Immediate return to IDLE.
  - Strobes drop asynchronously.
  - pop_data/pc_out cleared.
  - No partial result is reported.
- SP arithmetic is 8-bit and done by the SP block; this block does not modify sp_in.

Optional Feature:
- Macro: OC8051_STACK_GUARD_EN.
- With the macro, overflow check at start of a push-type op:
  - PUSH with sp_in==8'hFF, or CALL with sp_in>=8'hFE, triggers the guard.
  - Write states still run, but ram_wr=0 and ram_wr_sel=SEL_IDLE, so SP is not incremented.
  - stk_err set; done still pulses at normal time.
- With the macro, underflow check at start of a pop-type op:
  - POP with sp_in==8'h00, or RET/RETI with sp_in<=8'h01, triggers the guard.
  - Read selects are suppressed (SEL_IDLE).
  - Captured value forced to 0; stk_err set.
- stk_err is cleared only by reset.
- Without the macro: no checks, stk_err tied 0, op timing identical.

Test Plan:
- Reset, then PUSH data_in=8'hA5, sp_in=8'h07:
  - Exactly one cycle with ram_wr=1, ram_wr_sel=RWS_SP, ram_wr_data=8'hA5.
  - done in same cycle; busy low next cycle.
- CALL pc_in=16'h1234:
  - Writes 8'h34 then 8'h12 on consecutive cycles; done on 2nd.
- RET, with RAM model returning 8'h12 then 8'h56:
  - ram_rd_sel=RRS_SP for 2 cycles.
  - pc_out=16'h1256, pc_load=1 in 3rd cycle, irq_clr=0.
  - RETI with same data: additionally irq_clr=1 in same cycle.
- POP returns 8'h3C -> pop_data=8'h3C with done. Then start=1 asserted in the done cycle, and illegal op=3'b111 issued from IDLE:
  - Each gives an err pulse; no RAM activity.
- Reset pulled low during CALL WL:
  - ram_wr drops at once; busy=0; no WH write after reset release.
- With OC8051_STACK_GUARD_EN:
  - PUSH at sp_in=8'hFF gives no ram_wr, stk_err=1, done pulses.
  - stk_err stays 1 through subsequent legal ops until reset.
